// File: rtl/lsu_seq.sv
// Byte-serial load/store unit: little-endian multi-byte LOAD/STORE/PUSH/POP over
// internal RAM and an external read-only ROM, with a hardware stack pointer.
module lsu_seq #(
  parameter int AW        = 16,
  parameter int RAM_DEPTH = 32768,
  parameter int ROM_BASE  = 32768,
  parameter int MAX_BYTES = 4,
  parameter int SP_RESET  = 32768,
  localparam int LW = $clog2(MAX_BYTES + 1),
  localparam int DW = 8 * MAX_BYTES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [2:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [LW-1:0] req_len,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_fault,
  output logic [AW-1:0] rom_addr,
  input  logic [7:0]    rom_data,
  output logic [AW-1:0] sp
);

  localparam int RAW = $clog2(RAM_DEPTH);
  // Two spare bits so base+len-1 and sp+len never wrap during validation.
  localparam int XW  = AW + 2;

  localparam logic [2:0] OP_LOAD   = 3'd0;
  localparam logic [2:0] OP_STORE  = 3'd1;
  localparam logic [2:0] OP_PUSH   = 3'd2;
  localparam logic [2:0] OP_POP    = 3'd3;
  localparam logic [2:0] OP_SET_SP = 3'd4;

  localparam logic [XW-1:0] RAM_TOP  = XW'(RAM_DEPTH);
  localparam logic [XW-1:0] ROM_LO   = XW'(ROM_BASE);
  localparam logic [XW-1:0] ADDR_MAX = (XW'(1) << AW) - XW'(1);
  localparam logic [XW-1:0] SP_TOP   = XW'(SP_RESET);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state_reg;
  logic [AW-1:0] sp_reg;
  logic [AW-1:0] addr_reg;
  logic [2:0]    op_reg;
  logic [LW-1:0] len_reg;
  logic [LW-1:0] k_reg;
  logic [DW-1:0] wdata_reg;
  logic [DW-1:0] rdata_reg;
  logic          rom_sel_reg;
  logic          rsp_valid_reg;
  logic          rsp_fault_reg;

  logic [7:0] ram [RAM_DEPTH];

  logic [XW-1:0] len_x, sp_x, base_x, end_x;
  logic          in_ram, in_rom, bad_req;
  logic          is_read, is_write, last_byte;
  logic [7:0]    rd_byte, wr_byte;

  assign req_ready = (state_reg == IDLE) && rst;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_fault = rsp_fault_reg;
  assign rsp_rdata = rdata_reg;
  assign rom_addr  = addr_reg;
  assign sp        = sp_reg;

  // Request validation over the whole byte range, evaluated at acceptance.
  always_comb begin
    len_x = XW'(req_len);
    sp_x  = XW'(sp_reg);
    case (req_op)
      OP_PUSH: base_x = sp_x - len_x;
      OP_POP:  base_x = sp_x;
      default: base_x = XW'(req_addr);
    endcase
    end_x  = base_x + len_x - XW'(1);
    in_ram = (base_x < RAM_TOP) && (end_x < RAM_TOP);
    in_rom = (base_x >= ROM_LO) && (end_x <= ADDR_MAX);

    bad_req = 1'b0;
    if (req_op > OP_SET_SP) bad_req = 1'b1;
    if ((req_len == '0) || (len_x > XW'(MAX_BYTES))) bad_req = 1'b1;
    if (end_x > ADDR_MAX) bad_req = 1'b1;
    if (!in_ram && !in_rom) bad_req = 1'b1;
    if (in_rom && ((req_op == OP_STORE) || (req_op == OP_PUSH))) bad_req = 1'b1;
    if ((req_op == OP_PUSH) && (sp_x < len_x)) bad_req = 1'b1;
    if ((req_op == OP_POP) && ((sp_x + len_x) > SP_TOP)) bad_req = 1'b1;
  end

  always_comb begin
    is_read   = (op_reg == OP_LOAD) || (op_reg == OP_POP);
    is_write  = (op_reg == OP_STORE) || (op_reg == OP_PUSH);
    last_byte = (k_reg == (len_reg - LW'(1)));
    rd_byte   = rom_sel_reg ? rom_data : ram[addr_reg[RAW-1:0]];
    wr_byte   = '0;
    for (int i = 0; i < MAX_BYTES; i++)
      if (k_reg == LW'(i)) wr_byte = wdata_reg[8*i +: 8];
  end

  // Gated by rst so an abandoned access stops writing on the reset edge.
  always_ff @(posedge clk) begin
    if (rst && (state_reg == ACCESS) && is_write && !rom_sel_reg)
      ram[addr_reg[RAW-1:0]] <= wr_byte;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      sp_reg        <= AW'(SP_RESET);
      addr_reg      <= '0;
      op_reg        <= OP_LOAD;
      len_reg       <= '0;
      k_reg         <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      rom_sel_reg   <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_fault_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            op_reg        <= req_op;
            len_reg       <= req_len;
            wdata_reg     <= req_wdata;
            rdata_reg     <= '0;
            k_reg         <= '0;
            rsp_fault_reg <= 1'b0;
            if (req_op == OP_SET_SP) begin
              sp_reg        <= req_addr;
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else if (bad_req) begin
              rsp_fault_reg <= 1'b1;
              rsp_valid_reg <= 1'b1;
              state_reg     <= RESP;
            end else begin
              addr_reg    <= base_x[AW-1:0];
              rom_sel_reg <= in_rom;
              state_reg   <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (is_read)
            for (int i = 0; i < MAX_BYTES; i++)
              if (k_reg == LW'(i)) rdata_reg[8*i +: 8] <= rd_byte;
          k_reg <= k_reg + LW'(1);
          if (last_byte) begin
            if (op_reg == OP_PUSH) sp_reg <= sp_reg - AW'(len_reg);
            if (op_reg == OP_POP)  sp_reg <= sp_reg + AW'(len_reg);
            rsp_valid_reg <= 1'b1;
            state_reg     <= RESP;
          end else begin
            addr_reg <= addr_reg + AW'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
